// File: rtl/flit_injector.sv
// Network-interface packetizer: turns a descriptor plus payload stream into
// HEAD/BODY/TAIL flits on a registered output governed by router on/off flow control.
module flit_injector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned SRC_ID = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_msg_valid,
  output logic              o_msg_ready,
  input  logic [ADDR_W-1:0] i_msg_dest,
  input  logic [LEN_W-1:0]  i_msg_len,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_on_off,
  output logic              o_transmit_req,
  output logic [DATA_W+1:0] o_flit,
  output logic              o_busy,
  output logic [15:0]       o_pkt_count
);

  localparam int unsigned HDR_W = 2*ADDR_W + LEN_W + 8;
  localparam logic [ADDR_W-1:0] SRC_ADDR = ADDR_W'(SRC_ID);

  typedef enum logic {
    S_IDLE,
    S_BODY
  } state_e;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } ftype_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [7:0]          seq_q, seq_d;
  logic                req_q, req_d;
  logic [DATA_W+1:0]   flit_q, flit_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                free;
  logic                xfer;
  logic                msg_hs;
  logic                data_hs;
  logic [DATA_W-1:0]   head_pl;
  ftype_e              ftype;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      seq_q    <= '0;
      req_q    <= 1'b0;
      flit_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      seq_q    <= seq_d;
      req_q    <= req_d;
      flit_q   <= flit_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    seq_d    = seq_q;
    req_d    = req_q;
    flit_d   = flit_q;
    cnt_d    = cnt_q;
    ftype    = FT_HEAD;

    xfer    = req_q && i_on_off;
    msg_hs  = o_msg_ready && i_msg_valid;
    data_hs = o_data_ready && i_data_valid;

    head_pl = '0;
    head_pl[DATA_W-1 -: HDR_W] = {i_msg_dest, SRC_ADDR, i_msg_len, seq_q};

    if (xfer) begin
      req_d = 1'b0;
    end

    // TAIL and HEAD_TAIL both carry a 1 in the type MSB
    if (xfer && flit_q[DATA_W+1]) begin
      cnt_d = cnt_q + 16'd1;
    end

    // A reload in the same cycle as a transfer overrides the clear above
    unique case (state_q)
      S_IDLE: begin
        if (msg_hs) begin
          seq_d = seq_q + 8'd1;
          req_d = 1'b1;
          if (i_msg_len == '0) begin
            ftype = FT_HEAD_TAIL;
          end else begin
            ftype    = FT_HEAD;
            remain_d = i_msg_len;
            state_d  = S_BODY;
          end
          flit_d = {ftype, head_pl};
        end
      end
      S_BODY: begin
        if (data_hs) begin
          req_d    = 1'b1;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            ftype   = FT_TAIL;
            state_d = S_IDLE;
          end else begin
            ftype = FT_BODY;
          end
          flit_d = {ftype, i_data};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    free           = !req_q || i_on_off;
    o_msg_ready    = !reset && (state_q == S_IDLE) && free;
    o_data_ready   = !reset && (state_q == S_BODY) && free;
    o_transmit_req = req_q;
    o_flit         = flit_q;
    o_busy         = (state_q == S_BODY) || req_q;
    o_pkt_count    = cnt_q;
  end

endmodule

// File: doc/flit_injector.md
Name: flit_injector

Overview:
Network-interface packetizer that sits directly upstream of a router input port. It accepts a message descriptor (destination and payload length) and a stream of payload words. It segments each message into HEAD, BODY and TAIL flits and drives them into the router's input using the router's on/off flow-control signal. It sustains one flit per cycle while the router signals "on".

Parameters:
DATA_W, 32, flit payload width
ADDR_W, 4, node address width
LEN_W, 4, payload-length field width (0..2^LEN_W-1 body words)
SRC_ID, 0, this node's address, inserted into every head flit
(Flit width FLIT_W = DATA_W+2. Constraint: 2*ADDR_W+LEN_W+8 <= DATA_W.)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
i_msg_valid  in  1  message descriptor valid
o_msg_ready  out  1  descriptor accepted when valid&&ready
i_msg_dest  in  ADDR_W  destination node
i_msg_len  in  LEN_W  number of payload words
i_data_valid  in  1  payload word valid
o_data_ready  out  1  payload word accepted when valid&&ready
i_data  in  DATA_W  payload word
i_on_off  in  1  router input has space (1 = on)
o_transmit_req  out  1  o_flit valid
o_flit  out  DATA_W+2  [DATA_W+1:DATA_W] type (00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL), [DATA_W-1:0] payload
o_busy  out  1  packet in progress or flit pending
o_pkt_count  out  16  packets fully delivered, wraps

Behaviour:
- Reset (asynchronous, active-high): state IDLE, o_transmit_req=0, o_flit=0, remaining=0, seq=0, o_pkt_count=0, o_busy=0. Output ready signals are 0 while reset is asserted.
- Flit transfer: occurs on any posedge where o_transmit_req && i_on_off.
- o_flit and o_transmit_req are registered. The output register may load a new flit when it is free: free = !o_transmit_req || i_on_off.
- Once o_transmit_req is asserted it stays asserted, with o_flit stable, until the flit transfers. The request is never withdrawn.
- States: IDLE, BODY.
- IDLE:
  - o_msg_ready = free; o_data_ready = 0.
  - On descriptor handshake, load the head flit. Head payload = {dest, SRC_ID, len, seq, zero pad}, MSB-first.
  - Increment seq (8-bit, wraps 255->0).
  - len==0: type HEAD_TAIL, remain in IDLE.
  - len>0: type HEAD, remaining=len, go to BODY.
- BODY:
  - o_data_ready = free; o_msg_ready = 0.
  - On word handshake, load {BODY, i_data}, or {TAIL, i_data} when remaining==1. Decrement remaining.
  - On the remaining==1 handshake, return to IDLE.
- Latency: a flit appears on o_flit the cycle after its descriptor or word handshake.
- Throughput: back-to-back packets without bubbles. A new descriptor is accepted in the cycle that the TAIL handshake completes.
- o_pkt_count increments when a TAIL or HEAD_TAIL flit transfers, wrapping at 65535->0.
- o_busy = (state==BODY) || o_transmit_req.
- i_data_valid in IDLE and i_msg_valid in BODY are ignored; no ready is asserted for them.
- i_on_off low mid-packet: the current flit is held; no further data words are accepted.
- Simultaneous transfer and reload: the register takes the new flit; o_transmit_req stays high.
- Reset mid-packet: the partial packet is abandoned; o_transmit_req drops asynchronously and the counters clear.

Test Plan:
1. SRC_ID=2, dest=5, len=3, data A,B,C, i_on_off=1 throughout -> 4 consecutive flits: HEAD{5,2,3,seq0}, BODY A, BODY B, TAIL C; o_pkt_count=1.
2. len=0, dest=7 -> single HEAD_TAIL flit with len field 0; o_pkt_count increments; o_msg_ready high again the same cycle the flit transfers.
3. len=2, i_on_off forced low for 5 cycles after the head appears -> HEAD held stable with o_transmit_req=1 and o_data_ready=0; the sequence resumes unchanged when on; flit order preserved.
4. Two descriptors back-to-back (len=1 each), i_on_off=1 -> HEAD, TAIL, HEAD, TAIL on 4 consecutive cycles; seq fields 0 then 1.
5. Assert reset while the second BODY of a len=4 packet is pending -> o_transmit_req=0 immediately. After release, the next message starts with seq=0 and o_pkt_count=0.
6. Send 256 HEAD_TAIL messages -> the 257th head carries seq=0 (wrap verified).
